// File: rtl/mpi_credit_tx_if.sv
// Producer/bridge handshake bundle for mpi_credit_tx.
// The seq_out signal exists only when MPI_TX_SEQNUM_EN is defined.
interface mpi_credit_tx_if #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned CREDITS = 4
);
    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic             in_val;
    logic [WIDTH-1:0] in_data;
    logic             in_rdy;
    logic             val_out;
    logic [WIDTH-1:0] data_out;
    logic             yumi;
    logic             credit_ret;
    logic [CW-1:0]    credits_avail;
    logic             err_ovf;
`ifdef MPI_TX_SEQNUM_EN
    logic [7:0]       seq_out;
`endif

    modport master (
        output in_val, in_data, yumi, credit_ret,
        input  in_rdy, val_out, data_out, credits_avail, err_ovf
`ifdef MPI_TX_SEQNUM_EN
        , input seq_out
`endif
    );

    modport slave (
        input  in_val, in_data, yumi, credit_ret,
        output in_rdy, val_out, data_out, credits_avail, err_ovf
`ifdef MPI_TX_SEQNUM_EN
        , output seq_out
`endif
    );
endinterface

// File: rtl/mpi_credit_tx.sv
// Credit-gated transmit FIFO feeding an MPI send bridge.
// Define MPI_TX_SEQNUM_EN to add the 8-bit per-word sequence number output seq_out.
module mpi_credit_tx #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CREDITS = 4
) (
    input logic            clk,
    input logic            rst_n,
    mpi_credit_tx_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CredMax = CW'(CREDITS);
    localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StSend, StStall} state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             err_ovf_q, ovf_set;
    logic             val_q;
    state_e           state_q;
    logic             full, empty, empty_d, push, fire;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign push  = bus.in_val && bus.in_rdy;
    assign fire  = bus.yumi && val_q;

    always_comb begin
        wptr_d    = push ? (wptr_q + PtrOne) : wptr_q;
        rptr_d    = fire ? (rptr_q + PtrOne) : rptr_q;
        empty_d   = (wptr_d == rptr_d);
        credits_d = credits_q;
        ovf_set   = 1'b0;
        if (bus.credit_ret && !fire) begin
            if (credits_q == CredMax) begin
                ovf_set = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end else if (fire && !bus.credit_ret) begin
            credits_d = credits_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            credits_q <= CredMax;
            err_ovf_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            credits_q <= credits_d;
            err_ovf_q <= err_ovf_q | ovf_set;
        end
    end

    // Decisions use post-edge FIFO/credit values so val_out rises one cycle after a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            val_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty_d) begin
                        state_q <= (credits_d != '0) ? StSend : StStall;
                        val_q   <= (credits_d != '0);
                    end
                end
                StSend: begin
                    if (fire) begin
                        if (empty_d) begin
                            state_q <= StIdle;
                            val_q   <= 1'b0;
                        end else if (credits_d == '0) begin
                            state_q <= StStall;
                            val_q   <= 1'b0;
                        end else begin
                            state_q <= StSend;
                            val_q   <= 1'b1;
                        end
                    end
                end
                StStall: begin
                    if (credits_d != '0) begin
                        state_q <= StSend;
                        val_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    val_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MPI_TX_SEQNUM_EN
    logic [7:0] seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 8'd0;
        end else if (fire) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    assign bus.seq_out = seq_q;
`endif

    // Pointers reset asynchronously, so data_out reads zero while reset is held.
    assign bus.data_out      = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign bus.in_rdy        = rst_n && !full;
    assign bus.val_out       = val_q;
    assign bus.credits_avail = credits_q;
    assign bus.err_ovf       = err_ovf_q;
endmodule

// File: tb/tb_mpi_credit_tx.sv
// Scoreboard bench for mpi_credit_tx: accepted words are queued, popped and compared on yumi.
// Build with MPI_TX_SEQNUM_EN defined to also check seq_out wrap-around.
module tb_mpi_credit_tx;
    logic clk;
    logic rst_n;

    mpi_credit_tx_if #(.WIDTH(64), .CREDITS(4)) bus ();

    mpi_credit_tx #(.WIDTH(64), .DEPTH(4), .CREDITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks;
    int          errors;
    int          push_cnt;
    logic [63:0] q_data[$];
    int          q_seq[$];
    logic [63:0] exp_d;

    // Advance one cycle; record words the DUT accepts, then idle the inputs.
    task automatic step();
        if (bus.in_val && bus.in_rdy) begin
            q_data.push_back(bus.in_data);
            q_seq.push_back(push_cnt % 256);
            push_cnt++;
        end
        @(posedge clk);
        #1;
        bus.in_val     = 1'b0;
        bus.yumi       = 1'b0;
        bus.credit_ret = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("FAIL rst_val_out got=%0b exp=0", bus.val_out); end
        checks++; if (bus.data_out !== 64'd0) begin errors++; $display("FAIL rst_data_out got=%0h exp=0", bus.data_out); end
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got=%0b exp=0", bus.in_rdy); end
        checks++; if (bus.credits_avail !== 3'd4) begin errors++; $display("FAIL rst_credits got=%0d exp=4", bus.credits_avail); end
        checks++; if (bus.err_ovf !== 1'b0) begin errors++; $display("FAIL rst_err_ovf got=%0b exp=0", bus.err_ovf); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_in_rdy got=%0b exp=1", bus.in_rdy); end
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.in_val  = 1'b1;
        bus.in_data = 64'hDEAD_BEEF_0000_0001;
        step();
        checks++; if (bus.val_out !== 1'b1) begin errors++; $display("FAIL single_val_out got=%0b exp=1", bus.val_out); end
        checks++; if (bus.data_out !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL single_data got=%0h exp=deadbeef00000001", bus.data_out); end
        bus.yumi = 1'b1;
        if (q_data.size() == 0) begin checks++; errors++; $display("FAIL single_sb_empty got=0 exp=1 entries"); end
        else begin
            exp_d = q_data.pop_front(); void'(q_seq.pop_front());
            checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL single_pop got=%0h exp=%0h", bus.data_out, exp_d); end
        end
        step();
        checks++; if (bus.credits_avail !== 3'd3) begin errors++; $display("FAIL single_credits got=%0d exp=3", bus.credits_avail); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", bus.val_out); end
        bus.credit_ret = 1'b1;
        step();
        checks++; if (bus.credits_avail !== 3'd4) begin errors++; $display("FAIL single_ret got=%0d exp=4", bus.credits_avail); end
    endtask

    task automatic test_full();
        logic exp_rdy;
        for (int i = 0; i < 6; i++) begin
            bus.in_val  = 1'b1;
            bus.in_data = 64'h1000 + 64'(i);
            exp_rdy     = (i < 4);
            checks++; if (bus.in_rdy !== exp_rdy) begin errors++; $display("FAIL full_in_rdy[%0d] got=%0b exp=%0b", i, bus.in_rdy, exp_rdy); end
            step();
        end
        bus.yumi = 1'b1;
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%0b exp=0", bus.in_rdy); end
        checks++; if (bus.val_out !== 1'b1) begin errors++; $display("FAIL full_val_out got=%0b exp=1", bus.val_out); end
        if (q_data.size() != 0) begin
            exp_d = q_data.pop_front(); void'(q_seq.pop_front());
            checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL full_pop got=%0h exp=%0h", bus.data_out, exp_d); end
        end
        step();
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after_pop got=%0b exp=1", bus.in_rdy); end
        // Drain with a simultaneous credit return so the count holds at 3.
        for (int n = 0; n < 12 && q_data.size() > 0; n++) begin
            if (bus.val_out) begin
                bus.yumi       = 1'b1;
                bus.credit_ret = 1'b1;
                exp_d = q_data.pop_front(); void'(q_seq.pop_front());
                checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL full_drain got=%0h exp=%0h", bus.data_out, exp_d); end
            end
            step();
        end
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL full_drain_timeout got=%0d exp=0 left", q_data.size()); end
        checks++; if (bus.credits_avail !== 3'd3) begin errors++; $display("FAIL full_credits got=%0d exp=3", bus.credits_avail); end
        bus.credit_ret = 1'b1;
        step();
    endtask

    task automatic test_stall();
        int pushed = 0;
        int sent   = 0;
        for (int n = 0; n < 40 && !(sent == 4 && pushed == 5); n++) begin
            bus.in_val  = (pushed < 5);
            bus.in_data = 64'h2000 + 64'(pushed);
            if (bus.in_val && bus.in_rdy) pushed++;
            if (bus.val_out) begin
                bus.yumi = 1'b1;
                sent++;
                if (q_data.size() != 0) begin
                    exp_d = q_data.pop_front(); void'(q_seq.pop_front());
                    checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL stall_pop got=%0h exp=%0h", bus.data_out, exp_d); end
                end
            end
            step();
        end
        checks++; if (sent != 4 || pushed != 5) begin errors++; $display("FAIL stall_timeout got=sent%0d/push%0d exp=4/5", sent, pushed); end
        checks++; if (bus.credits_avail !== 3'd0) begin errors++; $display("FAIL stall_credits got=%0d exp=0", bus.credits_avail); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("FAIL stall_val_out got=%0b exp=0", bus.val_out); end
        bus.yumi = 1'b1;
        step();
        checks++; if (bus.credits_avail !== 3'd0) begin errors++; $display("FAIL stall_yumi_ignored got=%0d exp=0", bus.credits_avail); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("FAIL stall_hold got=%0b exp=0", bus.val_out); end
        bus.credit_ret = 1'b1;
        step();
        checks++; if (bus.val_out !== 1'b1) begin errors++; $display("FAIL stall_resume got=%0b exp=1", bus.val_out); end
        checks++; if (bus.credits_avail !== 3'd1) begin errors++; $display("FAIL stall_ret_credits got=%0d exp=1", bus.credits_avail); end
        bus.yumi = 1'b1;
        if (q_data.size() == 0) begin checks++; errors++; $display("FAIL stall_sb_empty got=0 exp=1 entries"); end
        else begin
            exp_d = q_data.pop_front(); void'(q_seq.pop_front());
            checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL stall_fifth got=%0h exp=%0h", bus.data_out, exp_d); end
        end
        step();
        checks++; if (bus.credits_avail !== 3'd0 || bus.val_out !== 1'b0) begin errors++; $display("FAIL stall_end got=%0d/%0b exp=0/0", bus.credits_avail, bus.val_out); end
        repeat (4) begin bus.credit_ret = 1'b1; step(); end
        checks++; if (bus.credits_avail !== 3'd4) begin errors++; $display("FAIL stall_refill got=%0d exp=4", bus.credits_avail); end
    endtask

    task automatic test_collide();
        for (int i = 0; i < 3; i++) begin
            bus.in_val  = 1'b1;
            bus.in_data = 64'h3000 + 64'(i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            bus.yumi       = 1'b1;
            bus.credit_ret = (i == 2);
            checks++; if (bus.val_out !== 1'b1) begin errors++; $display("FAIL collide_val_out[%0d] got=%0b exp=1", i, bus.val_out); end
            if (q_data.size() != 0) begin
                exp_d = q_data.pop_front(); void'(q_seq.pop_front());
                checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL collide_pop got=%0h exp=%0h", bus.data_out, exp_d); end
            end
            step();
            if (i == 1) begin
                checks++; if (bus.credits_avail !== 3'd2) begin errors++; $display("FAIL collide_pre got=%0d exp=2", bus.credits_avail); end
            end
        end
        checks++; if (bus.credits_avail !== 3'd2) begin errors++; $display("FAIL collide_same_cycle got=%0d exp=2", bus.credits_avail); end
        repeat (2) begin bus.credit_ret = 1'b1; step(); end
        checks++; if (bus.err_ovf !== 1'b0) begin errors++; $display("FAIL collide_no_ovf got=%0b exp=0", bus.err_ovf); end
        bus.credit_ret = 1'b1;
        step();
        checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL collide_ovf got=%0b exp=1", bus.err_ovf); end
        checks++; if (bus.credits_avail !== 3'd4) begin errors++; $display("FAIL collide_ovf_credits got=%0d exp=4", bus.credits_avail); end
        step();
        checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL collide_ovf_sticky got=%0b exp=1", bus.err_ovf); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin bus.in_val = 1'b1; bus.in_data = 64'h4000 + 64'(i); step(); end
        for (int i = 0; i < 3; i++) begin
            bus.yumi = 1'b1;
            if (bus.val_out && q_data.size() != 0) begin
                exp_d = q_data.pop_front(); void'(q_seq.pop_front());
                checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL rmid_pop got=%0h exp=%0h", bus.data_out, exp_d); end
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin bus.in_val = 1'b1; bus.in_data = 64'h5000 + 64'(i); step(); end
        checks++; if (bus.credits_avail !== 3'd1 || bus.val_out !== 1'b1) begin errors++; $display("FAIL rmid_setup got=%0d/%0b exp=1/1", bus.credits_avail, bus.val_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("FAIL rmid_val_out got=%0b exp=0", bus.val_out); end
        checks++; if (bus.credits_avail !== 3'd4) begin errors++; $display("FAIL rmid_credits got=%0d exp=4", bus.credits_avail); end
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL rmid_in_rdy got=%0b exp=0", bus.in_rdy); end
        checks++; if (bus.data_out !== 64'd0) begin errors++; $display("FAIL rmid_data got=%0h exp=0", bus.data_out); end
        checks++; if (bus.err_ovf !== 1'b0) begin errors++; $display("FAIL rmid_err_ovf got=%0b exp=0", bus.err_ovf); end
        q_data.delete();
        q_seq.delete();
        push_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rmid_release_rdy got=%0b exp=1", bus.in_rdy); end
        @(negedge clk);
        step();
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("FAIL rmid_empty got=%0b exp=0", bus.val_out); end
    endtask

    task automatic test_back_to_back();
        int pushed = 0;
        int sent   = 0;
        for (int n = 0; n < 1000 && sent < 257; n++) begin
            bus.in_val  = (pushed < 257);
            bus.in_data = {32'hB2B0_0000, 32'(pushed)};
            if (bus.in_val && bus.in_rdy) pushed++;
            if (bus.val_out) begin
                bus.yumi       = 1'b1;
                bus.credit_ret = 1'b1;
                if (q_data.size() == 0) begin checks++; errors++; $display("FAIL b2b_sb_empty got=0 exp=1 entries"); end
                else begin
                    exp_d = q_data.pop_front();
                    checks++; if (bus.data_out !== exp_d) begin errors++; $display("FAIL b2b_data got=%0h exp=%0h", bus.data_out, exp_d); end
`ifdef MPI_TX_SEQNUM_EN
                    begin
                        int exp_s;
                        exp_s = q_seq.pop_front();
                        checks++; if (bus.seq_out !== 8'(exp_s)) begin errors++; $display("FAIL b2b_seq got=%0d exp=%0d", bus.seq_out, exp_s); end
                        if (sent == 256) begin
                            checks++; if (bus.seq_out !== 8'd0) begin errors++; $display("FAIL b2b_seq_wrap got=%0d exp=0", bus.seq_out); end
                        end
                    end
`else
                    void'(q_seq.pop_front());
`endif
                end
                sent++;
            end
            step();
        end
        checks++; if (sent != 257) begin errors++; $display("FAIL b2b_timeout got=%0d exp=257 sends", sent); end
        checks++; if (bus.credits_avail !== 3'd4) begin errors++; $display("FAIL b2b_credits got=%0d exp=4", bus.credits_avail); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        push_cnt       = 0;
        rst_n          = 1'b0;
        bus.in_val     = 1'b0;
        bus.in_data    = '0;
        bus.yumi       = 1'b0;
        bus.credit_ret = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_stall();
        test_collide();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
